// File: rtl/n_bit_four_to_one_mux_if.sv
// n_bit_four_to_one_mux_if
//   Bundles the data/select/enable inputs and the combinational and
//   registered outputs of the N-bit 4-to-1 mux.
//   master : drives a, b, c, d, sel, en; observes out, out_q, sel_q, valid_q, changed
//   slave  : the mux itself (consumes inputs, drives outputs)
//   N      : data width in bits (N >= 1); must match the mux instance.
interface n_bit_four_to_one_mux_if #(
   parameter int N = 5
);
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] c;
   logic [N-1:0] d;
   logic [1:0]   sel;
   logic         en;
   logic [N-1:0] out;
   logic [N-1:0] out_q;
   logic [1:0]   sel_q;
   logic         valid_q;
   logic         changed;

   modport master (
      output a, b, c, d, sel, en,
      input  out, out_q, sel_q, valid_q, changed
   );

   modport slave (
      input  a, b, c, d, sel, en,
      output out, out_q, sel_q, valid_q, changed
   );
endinterface

// File: rtl/n_bit_four_to_one_mux.sv
// n_bit_four_to_one_mux
//   Selects one of four N-bit words (a/b/c/d) by a 2-bit select. The
//   selected word is presented combinationally on out, and a registered
//   copy (out_q, sel_q) is loaded when en is high. valid_q marks that a
//   load has happened since reset; changed pulses for one cycle when a
//   load altered out_q, and always after the first load following reset.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset of the registered path
//     bus   : slave view of n_bit_four_to_one_mux_if (a, b, c, d, sel, en in;
//             out, out_q, sel_q, valid_q, changed out)
module n_bit_four_to_one_mux #(
   parameter int N = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   n_bit_four_to_one_mux_if.slave    bus
);

   logic [N-1:0] mux_out;
   logic [N-1:0] out_d;
   logic [N-1:0] out_q;
   logic [1:0]   sel_d;
   logic [1:0]   sel_q;
   logic         valid_d;
   logic         valid_q;
   logic         changed_d;
   logic         changed_q;

   // Combinational word select; an unknown select propagates as all-X rather than favouring any input.
   always_comb begin
      mux_out = {N{1'bx}};
      case (bus.sel)
         2'b00:   mux_out = bus.a;
         2'b01:   mux_out = bus.b;
         2'b10:   mux_out = bus.c;
         2'b11:   mux_out = bus.d;
         default: mux_out = {N{1'bx}};
      endcase
   end

   // Next-state for the registered stage: load on en, otherwise hold with changed cleared.
   always_comb begin
      out_d     = out_q;
      sel_d     = sel_q;
      valid_d   = valid_q;
      changed_d = 1'b0;
      if (bus.en) begin
         out_d     = mux_out;
         sel_d     = bus.sel;
         valid_d   = 1'b1;
         // An invalid register counts as different so the first load after reset always flags.
         changed_d = (mux_out != out_q) || !valid_q;
      end else begin
         out_d     = out_q;
         sel_d     = sel_q;
         valid_d   = valid_q;
         changed_d = 1'b0;
      end
   end

   // Registered stage with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q     <= {N{1'b0}};
         sel_q     <= 2'b00;
         valid_q   <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         out_q     <= out_d;
         sel_q     <= sel_d;
         valid_q   <= valid_d;
         changed_q <= changed_d;
      end
   end

   assign bus.out     = mux_out;
   assign bus.out_q   = out_q;
   assign bus.sel_q   = sel_q;
   assign bus.valid_q = valid_q;
   assign bus.changed = changed_q;

endmodule

// File: tb/tb_n_bit_four_to_one_mux.sv
// tb_n_bit_four_to_one_mux
//   Directed bench for n_bit_four_to_one_mux at N = 5 and N = 1. Stimulus
//   pushes hand-computed expectations into a scoreboard queue and raises an
//   event; a separate monitor pops each entry and compares it with the
//   matching DUT output.
module tb_n_bit_four_to_one_mux;

   logic clk = 1'b0;
   logic rst_n;
   bit   clk_run = 1'b0;

   n_bit_four_to_one_mux_if #(.N(5)) bus5 ();
   n_bit_four_to_one_mux_if #(.N(1)) bus1 ();

   n_bit_four_to_one_mux #(.N(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));
   n_bit_four_to_one_mux #(.N(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   typedef enum int {K_OUT, K_OUT_Q, K_SEL_Q, K_VALID, K_CHANGED, K_OUT1} kind_e;
   typedef struct {
      string      name;
      kind_e      kind;
      logic [4:0] exp;
   } exp_t;

   exp_t sb_q[$];
   event check_ev;
   int   n_checks = 0;
   int   n_pass   = 0;

   // Gated clock: stays still until clk_run is set.
   initial begin
      forever begin
         #5;
         if (clk_run) clk = ~clk;
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [4:0] actual(kind_e k);
      case (k)
         K_OUT:     return bus5.out;
         K_OUT_Q:   return bus5.out_q;
         K_SEL_Q:   return {3'b000, bus5.sel_q};
         K_VALID:   return {4'b0000, bus5.valid_q};
         K_CHANGED: return {4'b0000, bus5.changed};
         K_OUT1:    return {4'b0000, bus1.out};
         default:   return 5'bxxxxx;
      endcase
   endfunction

   // Monitor: drains the scoreboard each time the stimulus says outputs are settled.
   initial begin
      forever begin
         @(check_ev);
         while (sb_q.size() != 0) begin
            exp_t       e;
            logic [4:0] act;
            e   = sb_q.pop_front();
            act = actual(e.kind);
            n_checks++;
            if (act === e.exp) n_pass++;
            else $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
         end
      end
   end

   task automatic expect_val(input string name, input kind_e kind, input logic [4:0] exp);
      exp_t e;
      e.name = name;
      e.kind = kind;
      e.exp  = exp;
      sb_q.push_back(e);
   endtask

   task automatic check_now();
      -> check_ev;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_reg(input string tag, input logic [4:0] oq, input logic [1:0] sq,
                             input logic v, input logic ch);
      expect_val({tag, "_out_q"},   K_OUT_Q,   oq);
      expect_val({tag, "_sel_q"},   K_SEL_Q,   {3'b000, sq});
      expect_val({tag, "_valid_q"}, K_VALID,   {4'b0000, v});
      expect_val({tag, "_changed"}, K_CHANGED, {4'b0000, ch});
      check_now();
   endtask

   initial begin
      rst_n    = 1'b0;
      bus5.a   = 5'b01010;
      bus5.b   = 5'b10101;
      bus5.c   = 5'b11011;
      bus5.d   = 5'b11100;
      bus5.sel = 2'b00;
      bus5.en  = 1'b0;
      bus1.a   = 1'b0;
      bus1.b   = 1'b0;
      bus1.c   = 1'b0;
      bus1.d   = 1'b0;
      bus1.sel = 2'b00;
      bus1.en  = 1'b0;
      #2;

      // 1. Combinational selection with no clock
      bus5.sel = 2'b00; #1; expect_val("comb_sel00", K_OUT, 5'b01010); check_now();
      bus5.sel = 2'b01; #1; expect_val("comb_sel01", K_OUT, 5'b10101); check_now();
      bus5.sel = 2'b10; #1; expect_val("comb_sel10", K_OUT, 5'b11011); check_now();
      bus5.sel = 2'b11; #1; expect_val("comb_sel11", K_OUT, 5'b11100); check_now();

      // 2. Reset held with en = 1 and clocks running
      bus5.en = 1'b1;
      clk_run = 1'b1;
      repeat (3) tick();
      expect_reg("rst_hold", 5'b00000, 2'b00, 1'b0, 1'b0);
      bus5.sel = 2'b10; #1;
      expect_val("rst_comb", K_OUT, 5'b11011); check_now();

      // 3. First load after release, then a hold cycle
      rst_n    = 1'b1;
      bus5.sel = 2'b01;
      bus5.en  = 1'b1;
      tick();
      expect_reg("load_b", 5'b10101, 2'b01, 1'b1, 1'b1);
      bus5.en = 1'b0;
      tick();
      expect_reg("hold_b", 5'b10101, 2'b01, 1'b1, 1'b0);

      // 4. Redundant load, then a differing load
      bus5.en = 1'b1;
      tick();
      expect_reg("reload_b", 5'b10101, 2'b01, 1'b1, 1'b0);
      bus5.sel = 2'b11;
      tick();
      expect_reg("load_d", 5'b11100, 2'b11, 1'b1, 1'b1);
      bus5.en = 1'b0;

      // 5. Asynchronous reset between edges, then a zero first load
      #2;
      rst_n = 1'b0;
      #1;
      expect_reg("async_rst", 5'b00000, 2'b00, 1'b0, 1'b0);
      tick();
      rst_n    = 1'b1;
      bus5.a   = 5'b00000;
      bus5.sel = 2'b00;
      bus5.en  = 1'b1;
      tick();
      expect_reg("zero_load", 5'b00000, 2'b00, 1'b1, 1'b1);

      // Hold while sel moves: registers keep the old load
      bus5.en  = 1'b0;
      bus5.sel = 2'b10;
      tick();
      expect_reg("hold_sel_move", 5'b00000, 2'b00, 1'b1, 1'b0);

      // Back-to-back differing loads keep changed high, a repeat drops it
      bus5.en = 1'b1;
      tick();
      expect_reg("b2b_c", 5'b11011, 2'b10, 1'b1, 1'b1);
      bus5.sel = 2'b11;
      tick();
      expect_reg("b2b_d", 5'b11100, 2'b11, 1'b1, 1'b1);
      tick();
      expect_reg("b2b_repeat", 5'b11100, 2'b11, 1'b1, 1'b0);
      bus5.en = 1'b0;

      // 6. N = 1: every a/b/c/d combination under every select
      for (int s = 0; s < 4; s++) begin
         for (int v = 0; v < 16; v++) begin
            logic [3:0] vec;
            logic [1:0] sv;
            vec = v[3:0];
            sv  = s[1:0];
            bus1.a   = vec[0];
            bus1.b   = vec[1];
            bus1.c   = vec[2];
            bus1.d   = vec[3];
            bus1.sel = sv;
            #1;
            expect_val("n1_mux", K_OUT1, {4'b0000, vec[sv]});
            check_now();
         end
      end

      #2;
      if (sb_q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
